// File: rtl/uart_video_pkg.sv
// Shared types and sizing helpers for the UART-to-framebuffer loader.
package uart_video_pkg;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  function automatic int frame_pix(input int img_w, input int img_h);
    return img_w * img_h;
  endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Pixel input strobe plus framebuffer write handshake.
// slave: the loader side; master: the pixel source / framebuffer side.
interface uart_frame_loader_if
  import uart_video_pkg::*;
#(
  parameter int ADDR_W = 15
) ();

  logic              pix_valid;
  pixel_t            pix_data;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  pixel_t            mem_wdata;

  modport slave (
    input  pix_valid, pix_data, mem_ack,
    output mem_req, mem_addr, mem_wdata
  );

  modport master (
    output pix_valid, pix_data, mem_ack,
    input  mem_req, mem_addr, mem_wdata
  );

endinterface

// File: rtl/pixel_hold_buf.sv
// One-entry pixel holding register used while a framebuffer write is pending.
// Priority: flush, then push (a push while full replaces the entry), then pop.
module pixel_hold_buf
  import uart_video_pkg::*;
(
  input  logic   i_clock,
  input  logic   i_reset_n,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  pixel_t i_data,
  output pixel_t o_data,
  output logic   o_full
);

  pixel_t r_data;
  logic   r_full;

  // Entry storage and valid flag.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_push) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/uart_frame_loader.sv
// Frame-load controller: takes assembled pixels, writes them to sequential
// framebuffer addresses over a req/ack port, buffering one pixel while a
// write is outstanding.
//
//   state | meaning
//   IDLE  | not loading; waits for start
//   ARMED | frame in progress, no write pending; waits for a pixel
//   WRITE | mem_req held high until mem_ack
//   DONE  | last pixel of the frame acked; start re-arms
module uart_frame_loader
  import uart_video_pkg::*;
#(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_abort,
  uart_frame_loader_if.slave bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun,
  output logic [ADDR_W-1:0] o_pix_count
);

  localparam int FRAME = frame_pix(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

  loader_state_t     r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_count;
  pixel_t            r_wdata;
  logic              r_overrun;
  logic              r_busy;
  logic              r_done;

  logic   w_in_write;
  logic   w_ack;
  logic   w_last;
  logic   w_buf_full;
  pixel_t w_buf_data;
  logic   w_push;
  logic   w_pop;
  logic   w_flush;

  assign w_in_write = (r_state == ST_WRITE);
  assign w_ack      = w_in_write && r_req && bus.mem_ack;
  assign w_last     = (r_addr == LAST_ADDR);

  // Hold-buffer control: fill while a write waits, refill when the buffered
  // pixel moves out on an ack, empty on abort or at end of frame.
  always_comb begin
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_flush = 1'b0;
    if ((r_state == ST_ARMED || w_in_write) && i_abort) begin
      w_flush = 1'b1;
    end else if (w_ack && w_last) begin
      w_flush = 1'b1;
    end else if (w_ack) begin
      w_pop  = w_buf_full;
      w_push = w_buf_full && bus.pix_valid;
    end else if (w_in_write) begin
      w_push = bus.pix_valid && !w_buf_full;
    end
  end

  pixel_hold_buf u_hold (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_data    (bus.pix_data),
    .o_data    (w_buf_data),
    .o_full    (w_buf_full)
  );

  // Main FSM with registered handshake and status outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state   <= ST_ARMED;
            r_addr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (i_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (bus.pix_valid) begin
            r_state <= ST_WRITE;
            r_wdata <= bus.pix_data;
            r_req   <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (i_abort) begin
            // Abort outranks a same-cycle ack; address and count stay for debug.
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_ack) begin
            r_count <= r_count + 1'b1;
            if (w_last) begin
              // Address parks on the last pixel instead of running past the frame.
              r_state <= ST_DONE;
              r_req   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (w_buf_full || bus.pix_valid) r_overrun <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (w_buf_full) begin
                r_wdata <= w_buf_data;
              end else if (bus.pix_valid) begin
                r_wdata <= bus.pix_data;
              end else begin
                r_state <= ST_ARMED;
                r_req   <= 1'b0;
              end
            end
          end else if (bus.pix_valid && w_buf_full) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_req;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_overrun     = r_overrun;
  assign o_pix_count   = r_count;

endmodule
